// File: rtl/iic_pkg.sv
// Shared definitions for the I2C target register file.
//   iic_slv_state_t : protocol FSM states
//   IIC_ACK/IIC_NACK: SDA level of the acknowledge bit
//   clog2_safe      : ceil(log2(n)), never less than 1
package iic_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_DEV_ADDR,
    S_DEV_ACK,
    S_REG_ADDR,
    S_REG_ACK,
    S_WR_DATA,
    S_WR_ACK,
    S_RD_LOAD,
    S_RD_DATA,
    S_RD_ACK
  } iic_slv_state_t;

  localparam logic IIC_ACK  = 1'b0;
  localparam logic IIC_NACK = 1'b1;

  function automatic int unsigned clog2_safe(input int unsigned n);
    int unsigned r;
    r = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/iic_bus_cond.sv
// SCL/SDA conditioning: SYNC_STAGES-deep synchronizers followed by a one-flop
// edge detector. The bus idles high, so every flop resets to 1.
//   clk, rst            : system clock, async active-high reset
//   scl_i, sda_i        : raw pin levels
//   scl_rise, scl_fall  : one-clk strobes on synchronized SCL edges
//   start_det, stop_det : SDA fall / rise while synchronized SCL is high
//   sda_s               : synchronized SDA level
module iic_bus_cond #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);

  logic [SYNC_STAGES-1:0] r_scl_sync;
  logic [SYNC_STAGES-1:0] r_sda_sync;
  logic                   r_scl_d;
  logic                   r_sda_d;
  logic                   w_scl_s;
  logic                   w_sda_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_d    <= 1'b1;
      r_sda_d    <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl_i};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_i};
      r_scl_d    <= w_scl_s;
      r_sda_d    <= w_sda_s;
    end
  end

  assign w_scl_s = r_scl_sync[SYNC_STAGES-1];
  assign w_sda_s = r_sda_sync[SYNC_STAGES-1];

  assign scl_rise  =  w_scl_s & ~r_scl_d;
  assign scl_fall  = ~w_scl_s &  r_scl_d;
  // SCL must be high on both samples so an SDA change around an SCL edge
  // is never taken for a bus condition.
  assign start_det =  w_scl_s &  r_scl_d &  r_sda_d & ~w_sda_s;
  assign stop_det  =  w_scl_s &  r_scl_d & ~r_sda_d &  w_sda_s;
  assign sda_s     =  w_sda_s;

endmodule

// File: rtl/iic_slave_regfile.sv
// I2C target with an internal byte-wide register file. SDA is driven
// open-drain only; SCL is never held, so there is no clock stretching.
//   clk, rst         : system clock (>= 10x SCL), async active-high reset
//   scl_i, sda_i     : bus pin levels
//   sda_oe           : 1 pulls SDA low
//   wr_en/addr/data  : one-clk strobe per byte written by the master
//   host_addr/rdata  : registered host read port, 1-clk latency
//   busy             : address-matched transfer in progress
module iic_slave_regfile
  import iic_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR       = 7'h3C,
  parameter int unsigned REG_ADDR_BYTES = 1,
  parameter int unsigned REG_DEPTH      = 256,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_oe,
  output logic        wr_en,
  output logic [15:0] wr_addr,
  output logic [7:0]  wr_data,
  input  logic [15:0] host_addr,
  output logic [7:0]  host_rdata,
  output logic        busy
);

  localparam int unsigned AW = clog2_safe(REG_DEPTH);

  logic w_scl_rise, w_scl_fall, w_start, w_stop, w_sda_s;

  iic_bus_cond #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_cond (
    .clk      (clk),
    .rst      (rst),
    .scl_i    (scl_i),
    .sda_i    (sda_i),
    .scl_rise (w_scl_rise),
    .scl_fall (w_scl_fall),
    .start_det(w_start),
    .stop_det (w_stop),
    .sda_s    (w_sda_s)
  );

  iic_slv_state_t r_state, w_state_nxt;

  logic [3:0]    r_bitcnt;
  logic [7:0]    r_sh;
  logic [7:0]    r_rsh;
  logic [7:0]    r_sub_hi;
  logic [1:0]    r_abyte;
  logic [AW-1:0] r_ptr;
  logic          r_rw;
  logic          r_mack;
  logic          r_sda_oe, w_sda_oe_nxt;
  logic          r_busy;
  logic          r_wr_en;
  logic [15:0]   r_wr_addr;
  logic [7:0]    r_wr_data;
  logic [7:0]    r_host_rdata;
  logic [7:0]    r_mem [REG_DEPTH];

  logic          w_byte_done;
  logic          w_addr_match;
  logic          w_last_sub;
  logic          w_in_byte;
  logic          w_ptr_bit7;
  logic [15:0]   w_sub_full;
  logic          w_unused;

  // Bytes complete on the SCL fall after the 8th rise; every state change
  // except RD_LOAD therefore happens on a synchronized SCL fall.
  assign w_byte_done  = w_scl_fall && (r_bitcnt == 4'd8);
  assign w_addr_match = (r_sh[7:1] == DEV_ADDR);
  assign w_last_sub   = (r_abyte == 2'(REG_ADDR_BYTES - 1));
  assign w_in_byte    = (r_state == S_DEV_ADDR) || (r_state == S_REG_ADDR) ||
                        (r_state == S_WR_DATA)  || (r_state == S_RD_DATA);
  assign w_ptr_bit7   = r_mem[r_ptr][7];
  assign w_sub_full   = (REG_ADDR_BYTES == 2) ? {r_sub_hi, r_sh} : {8'h00, r_sh};
  assign w_unused     = &{1'b0, host_addr, w_sub_full, r_sub_hi};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_stop) begin
      w_state_nxt = S_IDLE;
    end else if (w_start) begin
      w_state_nxt = S_DEV_ADDR;
    end else begin
      case (r_state)
        S_DEV_ADDR: if (w_byte_done) w_state_nxt = w_addr_match ? S_DEV_ACK : S_IDLE;
        S_DEV_ACK:  if (w_scl_fall)  w_state_nxt = r_rw ? S_RD_LOAD : S_REG_ADDR;
        S_REG_ADDR: if (w_byte_done) w_state_nxt = S_REG_ACK;
        S_REG_ACK:  if (w_scl_fall)
                      w_state_nxt = (r_abyte == 2'(REG_ADDR_BYTES)) ? S_WR_DATA : S_REG_ADDR;
        S_WR_DATA:  if (w_byte_done) w_state_nxt = S_WR_ACK;
        S_WR_ACK:   if (w_scl_fall)  w_state_nxt = S_WR_DATA;
        S_RD_LOAD:                   w_state_nxt = S_RD_DATA;
        S_RD_DATA:  if (w_byte_done) w_state_nxt = S_RD_ACK;
        S_RD_ACK:   if (w_scl_fall)
                      w_state_nxt = (r_mack == IIC_ACK) ? S_RD_LOAD : S_IDLE;
        default: ;
      endcase
    end
  end

  // The first bit of a read byte is taken straight from regfile[ptr] on the
  // fall that ends the preceding ACK, so it leaves one clk after that fall
  // even though the shift register is only loaded in RD_LOAD.
  always_comb begin
    w_sda_oe_nxt = r_sda_oe;
    if (w_stop || w_start) begin
      w_sda_oe_nxt = 1'b0;
    end else if (w_scl_fall) begin
      case (r_state)
        S_DEV_ADDR:           w_sda_oe_nxt = w_byte_done && w_addr_match;
        S_REG_ADDR, S_WR_DATA: w_sda_oe_nxt = w_byte_done;
        S_DEV_ACK:            w_sda_oe_nxt = r_rw ? ~w_ptr_bit7 : 1'b0;
        S_RD_DATA:            w_sda_oe_nxt = w_byte_done ? 1'b0 : ~r_rsh[6];
        S_RD_ACK:             w_sda_oe_nxt = (r_mack == IIC_ACK) ? ~w_ptr_bit7 : 1'b0;
        default:              w_sda_oe_nxt = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bitcnt     <= '0;
      r_sh         <= '0;
      r_rsh        <= '0;
      r_sub_hi     <= '0;
      r_abyte      <= '0;
      r_ptr        <= '0;
      r_rw         <= 1'b0;
      r_mack       <= IIC_NACK;
      r_sda_oe     <= 1'b0;
      r_busy       <= 1'b0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_host_rdata <= '0;
      for (int unsigned i = 0; i < REG_DEPTH; i++) r_mem[AW'(i)] <= '0;
    end else begin
      r_sda_oe     <= w_sda_oe_nxt;
      r_wr_en      <= 1'b0;
      r_host_rdata <= r_mem[host_addr[AW-1:0]];

      if (w_start || (w_state_nxt != r_state)) r_bitcnt <= '0;
      else if (w_scl_rise && w_in_byte && (r_bitcnt != 4'd8)) r_bitcnt <= r_bitcnt + 4'd1;

      if (w_scl_rise) r_sh <= {r_sh[6:0], w_sda_s};
      if (w_scl_rise && (r_state == S_RD_ACK)) r_mack <= w_sda_s;

      if (w_stop) begin
        r_busy <= 1'b0;
      end else if (!w_start) begin
        case (r_state)
          S_DEV_ADDR: if (w_byte_done) begin
            r_rw    <= r_sh[0];
            r_busy  <= w_addr_match;
            r_abyte <= '0;
          end
          S_REG_ADDR: if (w_byte_done) begin
            r_sub_hi <= r_sh;
            r_abyte  <= r_abyte + 2'd1;
            if (w_last_sub) r_ptr <= w_sub_full[AW-1:0];
          end
          S_WR_DATA: if (w_byte_done) begin
            r_mem[r_ptr] <= r_sh;
            r_wr_en      <= 1'b1;
            r_wr_addr    <= 16'(r_ptr);
            r_wr_data    <= r_sh;
            r_ptr        <= r_ptr + AW'(1);
          end
          S_RD_LOAD: begin
            r_rsh <= r_mem[r_ptr];
            r_ptr <= r_ptr + AW'(1);
          end
          S_RD_DATA: if (w_scl_fall && !w_byte_done) r_rsh <= {r_rsh[6:0], 1'b0};
          S_RD_ACK:  if (w_scl_fall && (r_mack == IIC_NACK)) r_busy <= 1'b0;
          default: ;
        endcase
      end
    end
  end

  assign sda_oe     = r_sda_oe;
  assign wr_en      = r_wr_en;
  assign wr_addr    = r_wr_addr;
  assign wr_data    = r_wr_data;
  assign host_rdata = r_host_rdata;
  assign busy       = r_busy;

endmodule

// File: tb/tb_iic_slave_regfile.sv
// Bench for iic_slave_regfile: a bit-banged I2C master drives two instances
// (1-byte sub-address / 256 regs, and 2-byte sub-address / 1024 regs).
// Expected writes and read bytes are queued by the stimulus and popped by
// independent monitors when the DUT produces them.
module tb_iic_slave_regfile;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]  scl  = 2'b11;
  logic [1:0]  mlow = 2'b00;
  logic        oe0, oe1, busy0, busy1, wen0, wen1;
  logic        line0, line1;
  logic [15:0] wr_addr0, wr_addr1;
  logic [7:0]  wr_data0, wr_data1;
  logic [15:0] host_addr0 = '0;
  logic [15:0] host_addr1 = '0;
  logic [7:0]  host_rdata0, host_rdata1;

  assign line0 = ~(mlow[0] | oe0);
  assign line1 = ~(mlow[1] | oe1);

  iic_slave_regfile #(
    .DEV_ADDR(7'h3C), .REG_ADDR_BYTES(1), .REG_DEPTH(256), .SYNC_STAGES(2)
  ) dut0 (
    .clk(clk), .rst(rst), .scl_i(scl[0]), .sda_i(line0), .sda_oe(oe0),
    .wr_en(wen0), .wr_addr(wr_addr0), .wr_data(wr_data0),
    .host_addr(host_addr0), .host_rdata(host_rdata0), .busy(busy0)
  );

  iic_slave_regfile #(
    .DEV_ADDR(7'h3C), .REG_ADDR_BYTES(2), .REG_DEPTH(1024), .SYNC_STAGES(2)
  ) dut1 (
    .clk(clk), .rst(rst), .scl_i(scl[1]), .sda_i(line1), .sda_oe(oe1),
    .wr_en(wen1), .wr_addr(wr_addr1), .wr_data(wr_data1),
    .host_addr(host_addr1), .host_rdata(host_rdata1), .busy(busy1)
  );

  int n_chk  = 0;
  int n_pass = 0;

  logic [23:0] exp_wr0[$];
  logic [23:0] exp_wr1[$];
  logic [7:0]  exp_rd[$];
  logic [7:0]  rd_obs;
  event        ev_rd;
  int          oe_hi_cnt0   = 0;
  int          busy_hi_cnt0 = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  // Write scoreboards
  always @(negedge clk) begin
    if (wen0) begin
      if (exp_wr0.size() == 0) begin
        n_chk++;
        $display("FAIL wr0_unexpected: got write addr 0x%0h data 0x%0h, expected none", wr_addr0, wr_data0);
      end else check("wr0", {wr_addr0, wr_data0}, exp_wr0.pop_front());
    end
    if (wen1) begin
      if (exp_wr1.size() == 0) begin
        n_chk++;
        $display("FAIL wr1_unexpected: got write addr 0x%0h data 0x%0h, expected none", wr_addr1, wr_data1);
      end else check("wr1", {wr_addr1, wr_data1}, exp_wr1.pop_front());
    end
    if (oe0)   oe_hi_cnt0++;
    if (busy0) busy_hi_cnt0++;
  end

  // Read-byte scoreboard
  always @(ev_rd) begin
    if (exp_rd.size() == 0) begin
      n_chk++;
      $display("FAIL rd_unexpected: got byte 0x%0h, expected none", rd_obs);
    end else check("rd_byte", rd_obs, exp_rd.pop_front());
  end

  // ---------------- bit-banged master ----------------
  task automatic q();
    repeat (5) @(negedge clk);
  endtask

  function automatic logic get_line(input int b);
    return (b == 0) ? line0 : line1;
  endfunction

  task automatic bus_start(input int b);
    mlow[b] = 1'b0; q(); scl[b] = 1'b1; q(); mlow[b] = 1'b1; q(); scl[b] = 1'b0; q();
  endtask

  task automatic bus_stop(input int b);
    mlow[b] = 1'b1; q(); scl[b] = 1'b1; q(); mlow[b] = 1'b0; q();
  endtask

  task automatic wbit(input int b, input logic v);
    mlow[b] = ~v; q(); scl[b] = 1'b1; q(); q(); scl[b] = 1'b0; q();
  endtask

  task automatic rbit(input int b, output logic v);
    mlow[b] = 1'b0; q(); scl[b] = 1'b1; q(); v = get_line(b); q(); scl[b] = 1'b0; q();
  endtask

  // exp_lvl: SDA level expected in the 9th bit (0 = ACK)
  task automatic wbyte(input int b, input logic [7:0] d, input logic exp_lvl, input string nm);
    logic a;
    for (int i = 7; i >= 0; i--) wbit(b, d[i]);
    rbit(b, a);
    check(nm, 32'(a), 32'(exp_lvl));
  endtask

  task automatic rbyte(input int b, input logic nack);
    logic [7:0] d;
    logic       v;
    for (int i = 7; i >= 0; i--) begin
      rbit(b, v);
      d[i] = v;
    end
    wbit(b, nack);
    rd_obs = d;
    ->ev_rd;
  endtask

  task automatic host_chk(input int b, input logic [15:0] a, input logic [7:0] e, input string nm);
    @(negedge clk);
    if (b == 0) host_addr0 = a; else host_addr1 = a;
    @(negedge clk); @(negedge clk);
    check(nm, 32'((b == 0) ? host_rdata0 : host_rdata1), 32'(e));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int oe_snap, busy_snap;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_sda_oe", 32'(oe0), 0);
    check("rst_wr_en", 32'(wen0), 0);
    check("rst_wr_addr", 32'(wr_addr0), 0);
    check("rst_wr_data", 32'(wr_data0), 0);
    check("rst_busy", 32'(busy0), 0);
    check("rst_host_rdata", 32'(host_rdata0), 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Write 0xA5,0x5A at 0x10
    exp_wr0.push_back({16'h0010, 8'hA5});
    exp_wr0.push_back({16'h0011, 8'h5A});
    bus_start(0);
    wbyte(0, 8'h78, 1'b0, "ack_dev_w");
    check("busy_after_match", 32'(busy0), 1);
    wbyte(0, 8'h10, 1'b0, "ack_sub");
    wbyte(0, 8'hA5, 1'b0, "ack_data0");
    wbyte(0, 8'h5A, 1'b0, "ack_data1");
    bus_stop(0);
    host_chk(0, 16'h0011, 8'h5A, "host_0x11");
    host_chk(0, 16'h0010, 8'hA5, "host_0x10");

    // Random read from 0x10 via repeated START
    exp_rd.push_back(8'hA5);
    exp_rd.push_back(8'h5A);
    bus_start(0);
    wbyte(0, 8'h78, 1'b0, "ack_dev_w2");
    wbyte(0, 8'h10, 1'b0, "ack_sub2");
    bus_start(0);
    wbyte(0, 8'h79, 1'b0, "ack_dev_r");
    rbyte(0, 1'b0);
    check("busy_mid_read", 32'(busy0), 1);
    rbyte(0, 1'b1);
    bus_stop(0);
    check("busy_after_stop", 32'(busy0), 0);

    // Wrong device address
    oe_snap = oe_hi_cnt0;
    busy_snap = busy_hi_cnt0;
    bus_start(0);
    wbyte(0, 8'h42, 1'b1, "nack_wrong_addr");
    bus_stop(0);
    check("wrong_addr_oe_cycles", 32'(oe_hi_cnt0 - oe_snap), 0);
    check("wrong_addr_busy_cycles", 32'(busy_hi_cnt0 - busy_snap), 0);

    // Pointer wrap on write and read
    exp_wr0.push_back({16'h00FF, 8'h11});
    exp_wr0.push_back({16'h0000, 8'h22});
    bus_start(0);
    wbyte(0, 8'h78, 1'b0, "ack_dev_wrap");
    wbyte(0, 8'hFF, 1'b0, "ack_sub_wrap");
    wbyte(0, 8'h11, 1'b0, "ack_wrap0");
    wbyte(0, 8'h22, 1'b0, "ack_wrap1");
    bus_stop(0);
    exp_rd.push_back(8'h11);
    exp_rd.push_back(8'h22);
    bus_start(0);
    wbyte(0, 8'h78, 1'b0, "ack_dev_wrap_w");
    wbyte(0, 8'hFF, 1'b0, "ack_sub_wrap_r");
    bus_start(0);
    wbyte(0, 8'h79, 1'b0, "ack_dev_wrap_r");
    rbyte(0, 1'b0);
    rbyte(0, 1'b1);
    bus_stop(0);
    host_chk(0, 16'h0000, 8'h22, "host_0x00");

    // STOP after 5 data bits: nothing written
    bus_start(0);
    wbyte(0, 8'h78, 1'b0, "ack_dev_abort");
    wbyte(0, 8'h20, 1'b0, "ack_sub_abort");
    wbit(0, 1'b1); wbit(0, 1'b0); wbit(0, 1'b1); wbit(0, 1'b1); wbit(0, 1'b0);
    bus_stop(0);
    check("busy_after_abort", 32'(busy0), 0);
    host_chk(0, 16'h0020, 8'h00, "host_0x20_unchanged");

    // 2-byte sub-address instance, including aliasing above REG_DEPTH
    exp_wr1.push_back({16'h0123, 8'h77});
    bus_start(1);
    wbyte(1, 8'h78, 1'b0, "b1_ack_dev");
    wbyte(1, 8'h01, 1'b0, "b1_ack_sub_hi");
    wbyte(1, 8'h23, 1'b0, "b1_ack_sub_lo");
    wbyte(1, 8'h77, 1'b0, "b1_ack_data");
    bus_stop(1);
    exp_rd.push_back(8'h77);
    bus_start(1);
    wbyte(1, 8'h78, 1'b0, "b1_ack_dev2");
    wbyte(1, 8'h05, 1'b0, "b1_ack_alias_hi");
    wbyte(1, 8'h23, 1'b0, "b1_ack_alias_lo");
    bus_start(1);
    wbyte(1, 8'h79, 1'b0, "b1_ack_dev_r");
    rbyte(1, 1'b1);
    bus_stop(1);
    host_chk(1, 16'h0123, 8'h77, "b1_host_0x123");
    host_chk(1, 16'h0523, 8'h77, "b1_host_alias");

    // Async reset during the target's ACK of a data byte
    exp_wr0.push_back({16'h0030, 8'h99});
    bus_start(0);
    wbyte(0, 8'h78, 1'b0, "ack_dev_rst");
    wbyte(0, 8'h30, 1'b0, "ack_sub_rst");
    for (int i = 7; i >= 0; i--) wbit(0, 1'(8'h99 >> i));
    mlow[0] = 1'b0; q(); scl[0] = 1'b1; q();
    check("oe_in_ack", 32'(oe0), 1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check("oe_released_by_rst", 32'(oe0), 0);
    @(negedge clk);
    rst = 1'b0;
    scl[0] = 1'b0; q();
    bus_stop(0);
    host_chk(0, 16'h0030, 8'h00, "rst_clear_0x30");
    host_chk(0, 16'h0010, 8'h00, "rst_clear_0x10");
    host_chk(0, 16'h00FF, 8'h00, "rst_clear_0xff");
    host_chk(1, 16'h0123, 8'h00, "b1_rst_clear");

    repeat (10) @(negedge clk);
    check("wr0_all_seen", 32'(exp_wr0.size()), 0);
    check("wr1_all_seen", 32'(exp_wr1.size()), 0);
    check("rd_all_seen", 32'(exp_rd.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/iic_slave_regfile.md
Name: iic_slave_regfile

Overview:
- I2C target (responder) with an internal byte-wide register file. It is the far end of the IR/camera IIC config masters.
- Lets sensor configuration sequences be checked in simulation, and provides an FPGA-side config target on hardware.
- Oversamples SCL/SDA on the system clock. Drives SDA open-drain only; never drives SCL, so no clock stretching.
- Exposes a write-event strobe and a host read port so the surrounding logic or bench can see the configured contents.

Parameters:
- DEV_ADDR, 7'h3C, 7-bit device address this target answers to.
- REG_ADDR_BYTES, 1, register sub-address width in bytes; legal values 1 or 2 (2 = MSB first).
- REG_DEPTH, 256, number of 8-bit registers; power of two, 2..65536.
- SYNC_STAGES, 2, synchronizer flops on scl_i/sda_i; minimum 2.

Ports:
- clk  in  1  system clock, at least 10x SCL rate (50 MHz nominal).
- rst  in  1  asynchronous active-high reset.
- scl_i  in  1  SCL pin level.
- sda_i  in  1  SDA pin level.
- sda_oe  out  1  1 = pull SDA low; 0 = release SDA.
- wr_en  out  1  one-cycle strobe per byte written by the master.
- wr_addr  out  16  register index of the write; zero-extended from log2(REG_DEPTH).
- wr_data  out  8  byte written.
- host_addr  in  16  host read index; only the low log2(REG_DEPTH) bits are used.
- host_rdata  out  8  regfile[host_addr], registered, 1-clk latency.
- busy  out  1  high from an address-matched START until STOP or NACK-to-idle.

Behaviour:
- Reset:
  - sda_oe=0, wr_en=0, wr_addr=0, wr_data=0, host_rdata=0, busy=0.
  - All registers cleared to 8'h00; register pointer cleared to 0; FSM in IDLE.
- Conditioning: scl/sda pass through SYNC_STAGES flops, then a 1-flop edge detector.
  - START = synced sda falls while synced scl is 1.
  - STOP = synced sda rises while synced scl is 1.
- Bit timing:
  - Data bits are sampled on synced-scl rising edge, MSB first.
  - sda_oe changes only on the cycle after a synced-scl falling edge, i.e. SYNC_STAGES+1 clk after the pin edge.
- FSM states: IDLE, DEV_ADDR, DEV_ACK, REG_ADDR, REG_ACK, WR_DATA, WR_ACK, RD_LOAD, RD_DATA, RD_ACK.
- Transitions:
  - IDLE -> DEV_ADDR on START.
  - DEV_ADDR: after 8 bits, if addr[7:1]==DEV_ADDR:
    - R/W=0 -> DEV_ACK, then REG_ADDR.
    - R/W=1 -> DEV_ACK, then RD_LOAD.
    - Mismatch -> IDLE with sda_oe=0 (no ACK) and busy=0.
  - REG_ADDR: collects REG_ADDR_BYTES bytes, each followed by REG_ACK; the pointer is loaded after the last byte, then -> WR_DATA.
  - WR_DATA: after 8 bits -> WR_ACK. That cycle: regfile[ptr]<=byte, wr_en=1 for one clk, wr_addr=ptr, wr_data=byte, ptr<=ptr+1.
  - RD_LOAD: shift register <= regfile[ptr], ptr<=ptr+1, then -> RD_DATA.
  - RD_DATA: sda_oe = ~shift[7] per bit.
  - RD_ACK: sda_oe=0; samples the master's ACK. ACK -> RD_LOAD; NACK -> IDLE.
  - ACK states assert sda_oe=1 from the falling edge after bit 8 until the falling edge after the 9th clock.
- Boundary conditions:
  - START in any state (repeated start): abort the current byte, release SDA, go to DEV_ADDR; the pointer is kept.
  - STOP in any state: go to IDLE, sda_oe=0, busy=0. A partial byte is discarded and no wr_en is issued.
  - A sub-address >= REG_DEPTH is reduced modulo REG_DEPTH. The pointer wraps REG_DEPTH-1 -> 0 on both reads and writes.
  - Read without a preceding sub-address write uses the current pointer.
  - Host read of an address written in the same clk returns the old value.
  - An asynchronous rst during a transfer releases SDA immediately. The next transfer requires a fresh START.

Decomposition:
- Package iic_pkg holds:
  - state enum iic_slv_state_t;
  - constants IIC_ACK=1'b0 and IIC_NACK=1'b1;
  - the shared function clog2_safe.
- One sub-module, iic_bus_cond: synchronizers plus edge detect. Outputs scl_rise, scl_fall, start_det, stop_det, sda_s.
- The register file stays inline as an array.

Test Plan:
- Write: START, 0x78 (0x3C W), sub 0x10, data 0xA5, 0x5A, STOP.
  - Target ACKs all 4 bytes.
  - wr_en pulses twice with (0x10,0xA5) and (0x11,0x5A).
  - host_rdata at 0x11 = 0x5A.
- Random read: START, 0x78, sub 0x10, repeated START, 0x79, master ACK then NACK, STOP.
  - SDA returns 0xA5 then 0x5A.
  - busy=0 one clk after STOP detection.
- Wrong address: START, 0x42, STOP.
  - sda_oe stays 0 throughout; no wr_en; busy stays 0.
- Wrap: sub 0xFF, write 0x11, 0x22 (REG_DEPTH=256).
  - Writes land at 0xFF and 0x00.
  - A subsequent read from 0xFF returns 0x11, 0x22.
- Aborts:
  - STOP after 5 bits of a data byte -> no wr_en, regfile unchanged.
  - rst pulsed mid-ACK -> sda_oe=0 within the same cycle; all registers read 0x00.
- REG_ADDR_BYTES=2, REG_DEPTH=1024: sub 0x0123, write 0x77.
  - wr_addr=0x0123, and a read returns 0x77.
  - Sub 0x0523 aliases to 0x0123.
